// File: rtl/rvv_fifo_push_packer_if.sv
// rvv_fifo_push_packer_if
//   Bundles the upstream beat handshake and the two FIFO write ports of the
//   RVV push packer. The master modport is the packer's own view; slave is the
//   view of whatever sits around it (upstream source plus FIFO).
interface rvv_fifo_push_packer_if #(
   parameter int unsigned DWIDTH      = 32,
   parameter int unsigned STAGE_DEPTH = 8
);
   // upstream beat
   logic [3:0]                       in_valid;
   logic [4*DWIDTH-1:0]              in_data;
   logic                             in_ready;
   logic                             flush;
   // FIFO write side
   logic                             push0;
   logic [DWIDTH-1:0]                push_data0;
   logic                             push1;
   logic [DWIDTH-1:0]                push_data1;
   logic                             full;
   logic                             almost_full;
   // status
   logic [$clog2(STAGE_DEPTH):0]     stage_count;

   modport master (
      input  in_valid, in_data, flush, full, almost_full,
      output in_ready, push0, push_data0, push1, push_data1, stage_count
   );

   modport slave (
      output in_valid, in_data, flush, full, almost_full,
      input  in_ready, push0, push_data0, push1, push_data1, stage_count
   );
endinterface

// File: rtl/rvv_fifo_push_packer.sv
// rvv_fifo_push_packer
//   Accepts up to four lane-masked words per cycle, compacts them in lane order
//   into a circular staging buffer and drains up to two words per cycle onto the
//   two FIFO write ports, never exceeding the space the FIFO reports.
//   Optional feature macro: RVV_PUSH_PACKER_BYPASS_EN
//     defined   - with an empty stage, an accepted beat's first words go straight
//                 to push0/push1 in the same cycle; only the rest is staged.
//     undefined - every word passes through staging (one cycle minimum latency).
module rvv_fifo_push_packer #(
   parameter int unsigned DWIDTH      = 32,
   parameter int unsigned STAGE_DEPTH = 8
) (
   input logic                    clk,
   input logic                    rst,
   rvv_fifo_push_packer_if.master bus
);

   localparam int unsigned PTR_W = $clog2(STAGE_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(STAGE_DEPTH - 4);

   // staging state
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DWIDTH-1:0] stage_q [STAGE_DEPTH];

   // beat compaction
   logic [2:0]        n_in;
   logic [1:0]        lane_pos [4];
   logic [DWIDTH-1:0] comp     [4];

   // handshake / drain control
   logic              ready;
   logic              accept;
   logic [1:0]        fifo_space;
   logic [1:0]        n_stage_out;
   logic [1:0]        n_byp;
   logic [1:0]        n_push;
   logic [2:0]        n_acc;

   // Count valid lanes and pack them, lowest lane first, into comp[0..n_in-1]
   always_comb begin
      n_in = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         lane_pos[i] = n_in[1:0];
         if (bus.in_valid[i]) begin
            n_in = n_in + 3'd1;
         end
      end
      for (int unsigned j = 0; j < 4; j++) begin
         comp[j] = '0;
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.in_valid[i] && (lane_pos[i] == 2'(j))) begin
               comp[j] = bus.in_data[i*DWIDTH +: DWIDTH];
            end
         end
      end
   end

   // Accept rule depends only on registered count, never on FIFO status
   always_comb begin
      ready  = !rst && (count_q <= READY_MAX) && !bus.flush;
      accept = ready && (|bus.in_valid);
   end

   // How many words leave this cycle, from the stage or through the bypass
   always_comb begin
      fifo_space  = bus.full ? 2'd0 : (bus.almost_full ? 2'd1 : 2'd2);
      n_stage_out = '0;
      if (!bus.flush) begin
         if (count_q >= CNT_W'(2)) begin
            n_stage_out = fifo_space;
         end else if (count_q == CNT_W'(1)) begin
            n_stage_out = (fifo_space == 2'd0) ? 2'd0 : 2'd1;
         end
      end
`ifdef RVV_PUSH_PACKER_BYPASS_EN
      n_byp = '0;
      if (accept && (count_q == '0)) begin
         n_byp = (n_in >= 3'(fifo_space)) ? fifo_space : n_in[1:0];
      end
`else
      n_byp = '0;
`endif
      // The two sources are exclusive: bypass only happens with an empty stage.
      n_push = (count_q == '0) ? n_byp : n_stage_out;
   end

   // Drive FIFO write ports; data is zero whenever its push is idle
   always_comb begin
      bus.push0      = (n_push != 2'd0);
      bus.push1      = (n_push == 2'd2);
      bus.push_data0 = '0;
      bus.push_data1 = '0;
      if (count_q == '0) begin
         if (bus.push0) bus.push_data0 = comp[0];
         if (bus.push1) bus.push_data1 = comp[1];
      end else begin
         if (bus.push0) bus.push_data0 = stage_q[rd_ptr_q];
         if (bus.push1) bus.push_data1 = stage_q[rd_ptr_q + PTR_W'(1)];
      end
      bus.in_ready    = ready;
      bus.stage_count = count_q;
   end

   // Next pointers and occupancy; bypassed words are written then skipped by rd_ptr
   always_comb begin
      n_acc    = accept ? n_in : 3'd0;
      rd_ptr_d = rd_ptr_q + PTR_W'(n_push);
      wr_ptr_d = wr_ptr_q + PTR_W'(n_acc);
      count_d  = count_q + CNT_W'(n_acc) - CNT_W'(n_push);
      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Write compacted words into consecutive stage slots starting at wr_ptr
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned j = 0; j < 4; j++) begin
            if (3'(j) < n_in) begin
               stage_q[wr_ptr_q + PTR_W'(j)] <= comp[j];
            end
         end
      end
   end

   // Structural invariants of the packer
   a_push1_needs_push0 : assert property (@(posedge clk) disable iff (rst)
      bus.push1 |-> bus.push0);
   a_count_bounded : assert property (@(posedge clk) disable iff (rst)
      count_q <= CNT_W'(STAGE_DEPTH));

endmodule

// File: tb/tb_rvv_fifo_push_packer.sv
// tb_rvv_fifo_push_packer
//   Directed bench for rvv_fifo_push_packer (DWIDTH=32, STAGE_DEPTH=8).
//   Expected values adapt when RVV_PUSH_PACKER_BYPASS_EN is defined.
module tb_rvv_fifo_push_packer;

   localparam int unsigned DW = 32;
   localparam int unsigned SD = 8;
`ifdef RVV_PUSH_PACKER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   rvv_fifo_push_packer_if #(.DWIDTH(DW), .STAGE_DEPTH(SD)) bus ();

   rvv_fifo_push_packer #(.DWIDTH(DW), .STAGE_DEPTH(SD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_push(input string tag, input logic p0, input logic [31:0] d0,
                              input logic p1, input logic [31:0] d1, input logic [3:0] cnt);
      check({tag, ".push0"},       64'(bus.push0),       64'(p0));
      check({tag, ".push_data0"},  64'(bus.push_data0),  64'(d0));
      check({tag, ".push1"},       64'(bus.push1),       64'(p1));
      check({tag, ".push_data1"},  64'(bus.push_data1),  64'(d1));
      check({tag, ".stage_count"}, 64'(bus.stage_count), 64'(cnt));
   endtask

   task automatic drive(input logic [3:0] v, input logic [31:0] l0, input logic [31:0] l1,
                        input logic [31:0] l2, input logic [31:0] l3,
                        input logic f, input logic af, input logic fl);
      bus.in_valid    = v;
      bus.in_data     = {l3, l2, l1, l0};
      bus.full        = f;
      bus.almost_full = af;
      bus.flush       = fl;
   endtask

   task automatic idle(input logic f, input logic af);
      drive(4'b0000, '0, '0, '0, '0, f, af, 1'b0);
   endtask

   // Start of a cycle: just after the rising edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic ready_is(input string tag, input logic exp);
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp));
   endtask

   initial begin
      rst = 1'b1;
      idle(1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      ready_is("reset", 1'b0);
      expect_push("reset", 1'b0, '0, 1'b0, '0, 4'd0);
      @(posedge clk);
      #1 rst = 1'b0;

`ifndef RVV_PUSH_PACKER_BYPASS_EN
      // full beat A..D, two words per cycle after one cycle of latency
      drive(4'b1111, 32'hA, 32'hB, 32'hC, 32'hD, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      ready_is("t1c0", 1'b1);
      expect_push("t1c0", 1'b0, '0, 1'b0, '0, 4'd0);
      next_cycle(); idle(1'b0, 1'b0); @(negedge clk);
      expect_push("t1c1", 1'b1, 32'hA, 1'b1, 32'hB, 4'd4);
      next_cycle(); @(negedge clk);
      expect_push("t1c2", 1'b1, 32'hC, 1'b1, 32'hD, 4'd2);
      next_cycle(); @(negedge clk);
      expect_push("t1c3", 1'b0, '0, 1'b0, '0, 4'd0);

      // non-contiguous mask 1010: lanes 1 and 3 compacted
      next_cycle();
      drive(4'b1010, 32'hDEAD0000, 32'h1111_0001, 32'hDEAD0002, 32'h2222_0003, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      expect_push("t2c0", 1'b0, '0, 1'b0, '0, 4'd0);
      next_cycle(); idle(1'b0, 1'b0); @(negedge clk);
      expect_push("t2c1", 1'b1, 32'h1111_0001, 1'b1, 32'h2222_0003, 4'd2);
      next_cycle(); @(negedge clk);
      expect_push("t2c2", 1'b0, '0, 1'b0, '0, 4'd0);
      next_cycle();
`endif

      // FIFO full: fill stage to 8, in_ready boundary at 4 and 8
      drive(4'b1111, 32'h30, 32'h31, 32'h32, 32'h33, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      ready_is("t3c0", 1'b1);
      expect_push("t3c0", 1'b0, '0, 1'b0, '0, 4'd0);
      next_cycle();
      drive(4'b1111, 32'h34, 32'h35, 32'h36, 32'h37, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      ready_is("t3c1", 1'b1);
      expect_push("t3c1", 1'b0, '0, 1'b0, '0, 4'd4);
      next_cycle();
      drive(4'b1111, 32'hEE, 32'hEE, 32'hEE, 32'hEE, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      ready_is("t3c2", 1'b0);
      expect_push("t3c2", 1'b0, '0, 1'b0, '0, 4'd8);
      // almost_full: one word per cycle
      next_cycle(); idle(1'b0, 1'b1); @(negedge clk);
      expect_push("t3c3", 1'b1, 32'h30, 1'b0, '0, 4'd8);
      next_cycle(); @(negedge clk);
      expect_push("t3c4", 1'b1, 32'h31, 1'b0, '0, 4'd7);
      next_cycle(); @(negedge clk);
      expect_push("t3c5", 1'b1, 32'h32, 1'b0, '0, 4'd6);

      // flush with 5 staged words, then a fresh beat
      next_cycle();
      drive(4'b1111, 32'hEE, 32'hEE, 32'hEE, 32'hEE, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      ready_is("t5c0", 1'b0);
      expect_push("t5c0", 1'b0, '0, 1'b0, '0, 4'd5);
      next_cycle();
      drive(4'b0011, 32'h50, 32'h51, 32'hEE, 32'hEE, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      ready_is("t5c1", 1'b1);
      expect_push("t5c1", BYP, BYP ? 32'h50 : 32'h0, BYP, BYP ? 32'h51 : 32'h0, 4'd0);
      next_cycle(); idle(1'b0, 1'b0); @(negedge clk);
      expect_push("t5c2", !BYP, BYP ? 32'h0 : 32'h50, !BYP, BYP ? 32'h0 : 32'h51,
                  BYP ? 4'd0 : 4'd2);
      next_cycle(); @(negedge clk);
      expect_push("t5c3", 1'b0, '0, 1'b0, '0, 4'd0);

      // accept while draining, write pointer wraps (slots 2..5 then 6,7,0,1)
      next_cycle();
      drive(4'b1111, 32'h40, 32'h41, 32'h42, 32'h43, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      ready_is("t4c0", 1'b1);
      expect_push("t4c0", 1'b0, '0, 1'b0, '0, 4'd0);
      next_cycle();
      drive(4'b1111, 32'h44, 32'h45, 32'h46, 32'h47, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      ready_is("t4c1", 1'b1);
      expect_push("t4c1", 1'b1, 32'h40, 1'b1, 32'h41, 4'd4);
      next_cycle(); idle(1'b0, 1'b0); @(negedge clk);
      ready_is("t4c2", 1'b0);
      expect_push("t4c2", 1'b1, 32'h42, 1'b1, 32'h43, 4'd6);
      next_cycle(); @(negedge clk);
      expect_push("t4c3", 1'b1, 32'h44, 1'b1, 32'h45, 4'd4);
      next_cycle(); @(negedge clk);
      expect_push("t4c4", 1'b1, 32'h46, 1'b1, 32'h47, 4'd2);
      next_cycle(); @(negedge clk);
      ready_is("t4c5", 1'b1);
      expect_push("t4c5", 1'b0, '0, 1'b0, '0, 4'd0);

      // three-lane beat on empty stage: bypass vs staged latency
      next_cycle();
      drive(4'b0111, 32'h60, 32'h61, 32'h62, 32'hEE, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      expect_push("t6c0", BYP, BYP ? 32'h60 : 32'h0, BYP, BYP ? 32'h61 : 32'h0, 4'd0);
      next_cycle(); idle(1'b0, 1'b0); @(negedge clk);
      expect_push("t6c1", 1'b1, BYP ? 32'h62 : 32'h60, !BYP, BYP ? 32'h0 : 32'h61,
                  BYP ? 4'd1 : 4'd3);
      next_cycle(); @(negedge clk);
      expect_push("t6c2", !BYP, BYP ? 32'h0 : 32'h62, 1'b0, '0, BYP ? 4'd0 : 4'd1);
      next_cycle(); @(negedge clk);
      expect_push("t6c3", 1'b0, '0, 1'b0, '0, 4'd0);

      // mid-operation reset loses staged words
      next_cycle();
      drive(4'b1111, 32'h70, 32'h71, 32'h72, 32'h73, 1'b1, 1'b0, 1'b0);
      next_cycle(); idle(1'b0, 1'b0); @(negedge clk);
      expect_push("t7c0", 1'b1, 32'h70, 1'b1, 32'h71, 4'd4);
      #1 rst = 1'b1;
      #1;
      ready_is("t7rst", 1'b0);
      expect_push("t7rst", 1'b0, '0, 1'b0, '0, 4'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      ready_is("t7c1", 1'b1);
      expect_push("t7c1", 1'b0, '0, 1'b0, '0, 4'd0);
      next_cycle(); @(negedge clk);
      expect_push("t7c2", 1'b0, '0, 1'b0, '0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
